// File: rtl/ibus_wb_if.sv
// Purpose : instruction-fetch bridge from the openmips ROM port to a Wishbone B4 classic read master.
// Latency : N+2 cycles per fetch for N slave wait states; the word is presented combinationally in the ack cycle.
// Backpres: stallreq_o holds the pipeline while a fetch is outstanding; a word that lands during an external stall is parked in rd_buf.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   cpu_ce_i/addr_i   fetch request from core rom_ce_o / rom_addr_o
//   cpu_data_o        fetched instruction to core rom_data_i (0 when nothing valid)
//   stall_i, flush_i  pipeline stall vector and fetch discard from ctrl
//   stallreq_o        stall request to ctrl while waiting on the bus
//   err_o             one-cycle pulse after a fetch timeout
//   wb_*              Wishbone B4 classic master (read only)

module ibus_wb_if #(
    parameter int unsigned TIMEOUT = 255   // BUSY cycles before abort; 0 disables
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY       = 2'd1,
        ST_WAIT_STALL = 2'd2
    } state_t;

    // Timeout fires on the last permitted BUSY cycle, i.e. when tcnt reaches TIMEOUT-1.
    localparam bit          LP_TO_EN = (TIMEOUT != 0);
    localparam logic [15:0] LP_TLAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_cyc;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_rd_buf;
    logic [15:0] r_tcnt;
    logic        r_err;

    state_t      w_state_nxt;
    logic        w_cyc_nxt;
    logic [3:0]  w_sel_nxt;
    logic [31:0] w_adr_nxt;
    logic [31:0] w_rd_buf_nxt;
    logic [15:0] w_tcnt_nxt;
    logic        w_err_nxt;
    logic        w_stallreq;
    logic [31:0] w_cpu_data;
    logic        w_timeout;
    logic        w_start;

    assign w_timeout = LP_TO_EN && (r_tcnt == LP_TLAST);
    assign w_start   = cpu_ce_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_sel    <= 4'h0;
            r_adr    <= 32'h0;
            r_rd_buf <= 32'h0;
            r_tcnt   <= 16'h0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_sel    <= w_sel_nxt;
            r_adr    <= w_adr_nxt;
            r_rd_buf <= w_rd_buf_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_sel_nxt    = r_sel;
        w_adr_nxt    = r_adr;          // address held for the whole bus cycle and beyond
        w_rd_buf_nxt = r_rd_buf;
        w_tcnt_nxt   = r_tcnt;
        w_err_nxt    = 1'b0;
        w_stallreq   = 1'b0;
        w_cpu_data   = 32'h0;

        unique case (r_state)
            ST_IDLE: begin
                // Stall is raised combinationally so the core freezes in the request cycle itself.
                w_stallreq = w_start;
                if (w_start) begin
                    w_cyc_nxt   = 1'b1;
                    w_sel_nxt   = 4'hF;
                    w_adr_nxt   = cpu_addr_i;
                    w_tcnt_nxt  = 16'h0;
                    w_state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (flush_i) begin
                    // Abandon the cycle; any later ack lands outside BUSY and is ignored.
                    w_cyc_nxt   = 1'b0;
                    w_sel_nxt   = 4'h0;
                    w_state_nxt = ST_IDLE;
                end else if (wb_ack_i) begin
                    w_cyc_nxt    = 1'b0;
                    w_sel_nxt    = 4'h0;
                    w_rd_buf_nxt = wb_dat_i;
                    w_cpu_data   = wb_dat_i;
                    w_state_nxt  = (stall_i == 6'd0) ? ST_IDLE : ST_WAIT_STALL;
                end else if (w_timeout) begin
                    // Release the pipeline with a zero word (NOP) and flag the error next cycle.
                    w_cyc_nxt   = 1'b0;
                    w_sel_nxt   = 4'h0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stallreq = 1'b1;
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end

            ST_WAIT_STALL: begin
                // Pipeline is frozen by someone else: keep replaying the captured word.
                w_cpu_data = r_rd_buf;
                if ((stall_i == 6'd0) || flush_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
                w_sel_nxt   = 4'h0;
            end
        endcase
    end

    assign cpu_data_o = w_cpu_data;
    assign stallreq_o = w_stallreq;
    assign err_o      = r_err;
    assign wb_adr_o   = r_adr;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_cyc;
    assign wb_sel_o   = r_sel;
    assign wb_we_o    = 1'b0;

endmodule

// File: tb/tb_ibus_wb_if.sv
// Purpose : self-checking bench for ibus_wb_if (cycle table plus scoreboarded random fetches).
// Latency : inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpres: the bench acts as core, ctrl and Wishbone slave; ack timing is chosen per fetch.

module tb_ibus_wb_if;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;

    ibus_wb_if #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] addr;
        logic [5:0]  stall;
        logic        flush;
        logic        ack;
        logic [31:0] dat;
        logic        chk;
        logic        e_sr;
        logic [31:0] e_data;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic        e_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] adr_q[$];
    int          n_pass;
    int          n_total;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic v(input logic r, input logic ce, input logic [31:0] a, input logic [5:0] st,
                     input logic fl, input logic ak, input logic [31:0] d, input logic c,
                     input logic esr, input logic [31:0] ed, input logic ec, input logic [31:0] ea,
                     input logic ee);
        vec_t t;
        t.rst = r; t.ce = ce; t.addr = a; t.stall = st; t.flush = fl; t.ack = ak; t.dat = d;
        t.chk = c; t.e_sr = esr; t.e_data = ed; t.e_cyc = ec; t.e_adr = ea; t.e_err = ee;
        vecs.push_back(t);
    endtask

    // Slave read data as a function of the word address.
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_rst;
        logic [31:0] a;
        logic [31:0] e;
        int          n_wait;
        int          n_sr;
        n_pass = 0;
        n_total = 0;

        // rst ce addr stall flush ack dat | chk sr data cyc adr err
        v(1,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // 0-wait read
        v(0,1,32'h4,  6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'h4,  6'h00,0,1,32'h34011100,1, 0,32'h34011100,1,32'h4,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // 3-wait read; core address wiggles during BUSY and must be ignored
        v(0,1,32'h100,6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'h200,6'h00,0,0,32'h0,       1, 1,32'h0,1,32'h100,0);
        v(0,1,32'h200,6'h00,0,0,32'h0,       1, 1,32'h0,1,32'h100,0);
        v(0,1,32'h200,6'h00,0,0,32'h0,       1, 1,32'h0,1,32'h100,0);
        v(0,1,32'h200,6'h00,0,1,32'h1020,    1, 0,32'h1020,1,32'h100,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // ack during external stall, stray ack in WAIT_STALL
        v(0,1,32'h8,  6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'h8,  6'h0F,0,1,32'hDEADBEEF,1, 0,32'hDEADBEEF,1,32'h8,0);
        v(0,1,32'h8,  6'h0F,0,1,32'h11111111,1, 0,32'hDEADBEEF,0,32'h0,0);
        v(0,1,32'h8,  6'h0F,0,0,32'h0,       1, 0,32'hDEADBEEF,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'hDEADBEEF,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // flush one cycle into a 5-wait fetch, late ack ignored
        v(0,1,32'hC,  6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'hC,  6'h00,0,0,32'h0,       1, 1,32'h0,1,32'hC,0);
        v(0,1,32'hC,  6'h00,1,0,32'h0,       1, 0,32'h0,1,32'hC,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,1,32'hCAFEF00D,1, 0,32'h0,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // timeout after 8 BUSY cycles
        v(0,1,32'h10, 6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        for (int i = 0; i < 7; i++)
            v(0,1,32'h10,6'h00,0,0,32'h0,    1, 1,32'h0,1,32'h10,0);
        v(0,1,32'h10, 6'h00,0,0,32'h0,       1, 0,32'h0,1,32'h10,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,1);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        // reset during a wait state, then a clean fetch
        v(0,1,32'h20, 6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'h20, 6'h00,0,0,32'h0,       1, 1,32'h0,1,32'h20,0);
        v(1,0,32'h0,  6'h00,0,0,32'h0,       0, 0,32'h0,0,32'h0,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);
        v(0,1,32'h24, 6'h00,0,0,32'h0,       1, 1,32'h0,0,32'h0,0);
        v(0,1,32'h24, 6'h00,0,1,32'h12345678,1, 0,32'h12345678,1,32'h24,0);
        v(0,0,32'h0,  6'h00,0,0,32'h0,       1, 0,32'h0,0,32'h0,0);

        rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = 32'h0; stall_i = 6'h0;
        flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        repeat (2) @(posedge clk);

        prev_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; cpu_ce_i = vecs[i].ce; cpu_addr_i = vecs[i].addr;
            stall_i = vecs[i].stall; flush_i = vecs[i].flush;
            wb_ack_i = vecs[i].ack; wb_dat_i = vecs[i].dat;
            @(negedge clk);
            if (vecs[i].chk) begin
                chk($sformatf("row%0d_stallreq", i), {31'h0, stallreq_o}, {31'h0, vecs[i].e_sr});
                chk($sformatf("row%0d_data", i), cpu_data_o, vecs[i].e_data);
                chk($sformatf("row%0d_cyc", i), {31'h0, wb_cyc_o}, {31'h0, vecs[i].e_cyc});
                chk($sformatf("row%0d_stb", i), {31'h0, wb_stb_o}, {31'h0, vecs[i].e_cyc});
                chk($sformatf("row%0d_sel", i), {28'h0, wb_sel_o}, vecs[i].e_cyc ? 32'hF : 32'h0);
                chk($sformatf("row%0d_we", i), {31'h0, wb_we_o}, 32'h0);
                chk($sformatf("row%0d_err", i), {31'h0, err_o}, {31'h0, vecs[i].e_err});
                if (vecs[i].e_cyc || vecs[i].rst || prev_rst)
                    chk($sformatf("row%0d_adr", i), wb_adr_o, vecs[i].e_adr);
            end
            prev_rst = vecs[i].rst;
        end

        // Back-to-back random fetches against a scoreboard.
        for (int i = 0; i < 20; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            n_wait = $urandom_range(0, 4);
            @(posedge clk);
            #1;
            rst = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = a; stall_i = 6'h0;
            flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
            exp_q.push_back(fdat(a));
            adr_q.push_back(a);
            @(negedge clk);
            chk($sformatf("sb%0d_idle_sr", i), {31'h0, stallreq_o}, 32'h1);
            chk($sformatf("sb%0d_idle_cyc", i), {31'h0, wb_cyc_o}, 32'h0);
            n_sr = 1;
            for (int k = 0; k <= n_wait; k++) begin
                @(posedge clk);
                #1;
                cpu_addr_i = $urandom & 32'hFFFF_FFFC;
                wb_ack_i = (k == n_wait);
                wb_dat_i = wb_ack_i ? fdat(wb_adr_o) : $urandom;
                @(negedge clk);
                if (!wb_ack_i) begin
                    n_sr = n_sr + int'(stallreq_o);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("sb%0d_data", i), cpu_data_o, e);
                    e = adr_q.pop_front();
                    chk($sformatf("sb%0d_adr", i), wb_adr_o, e);
                    chk($sformatf("sb%0d_ack_cyc", i), {31'h0, wb_cyc_o}, 32'h1);
                    chk($sformatf("sb%0d_ack_sr", i), {31'h0, stallreq_o}, 32'h0);
                end
            end
            chk($sformatf("sb%0d_stall_len", i), n_sr, n_wait + 1);
        end

        @(posedge clk);
        #1;
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        chk("sb_final_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("sb_queue_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibus_wb_if.md
# ibus_wb_if

Instruction-fetch bus interface that sits directly upstream of the `openmips` core's ROM port. It converts the core's single-cycle fetch request (`rom_ce_o`/`rom_addr_o`) into a Wishbone B4 classic read cycle with arbitrary wait states and supplies the fetched word back on `rom_data_i`. While a fetch is outstanding it raises a stall request to `ctrl`. If the word arrives while the pipeline is stalled for another reason, it holds the word until the stall releases.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum BUSY cycles before the fetch is aborted; 0 disables the timeout; legal range 0..65535.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_ce_i`  in  1  fetch enable, driven by core `rom_ce_o`.
- `cpu_addr_i`  in  32  fetch byte address, driven by core `rom_addr_o`; word aligned.
- `cpu_data_o`  out  32  fetched instruction, drives core `rom_data_i`.
- `stall_i`  in  6  pipeline stall vector from `ctrl`.
- `flush_i`  in  1  discard the outstanding fetch.
- `stallreq_o`  out  1  stall request to `ctrl`.
- `err_o`  out  1  one-cycle pulse when a fetch times out.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_ack_i`  in  1  Wishbone acknowledge.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_sel_o`  out  4  byte selects; always 4'hF during a cycle.
- `wb_we_o`  out  1  always 0; the block only reads.

## Operation
- State machine with three states: IDLE, BUSY, WAIT_STALL. It also holds `rd_buf[31:0]` and `tcnt[15:0]`.
- IDLE:
  - Condition: `cpu_ce_i`=1 and `flush_i`=0.
  - Registered actions: set `wb_cyc_o`=`wb_stb_o`=1, `wb_adr_o`=`cpu_addr_i`, `wb_sel_o`=4'hF; clear `tcnt`; go to BUSY.
  - Combinational outputs: `stallreq_o`=`cpu_ce_i` & ~`flush_i`; `cpu_data_o`=0.
- BUSY, with `wb_ack_i`=1:
  - Registered actions: drop `cyc`/`stb`/`sel`; load `rd_buf`<=`wb_dat_i`.
  - Next state: IDLE if `stall_i`==0, otherwise WAIT_STALL.
  - Combinational outputs, same cycle: `cpu_data_o`=`wb_dat_i`, `stallreq_o`=0.
- BUSY, without `wb_ack_i`:
  - `stallreq_o`=1, `cpu_data_o`=0; `tcnt` increments.
- BUSY, timeout (`TIMEOUT`≠0, `tcnt`==`TIMEOUT`-1, no ack):
  - Drop `cyc`/`stb`, pulse `err_o` for the next cycle, go to IDLE.
  - Combinational outputs that cycle: `stallreq_o`=0, `cpu_data_o`=0; the core executes a NOP.
- BUSY, `flush_i`=1 (priority over ack and timeout):
  - Drop `cyc`/`stb`, discard the data, go to IDLE.
  - Outputs: `stallreq_o`=0, `cpu_data_o`=0.
- WAIT_STALL:
  - Outputs: `cpu_data_o`=`rd_buf`, `stallreq_o`=0.
  - Go to IDLE when `stall_i`==0 or `flush_i`=1.
  - No new bus cycle is issued from this state.
- `wb_adr_o` stays stable for the whole cycle and ignores changes on `cpu_addr_i`.
- Any `wb_ack_i` seen outside BUSY is ignored.

## Timing
- Reset: all outputs are 0, state is IDLE, `rd_buf`=0, `tcnt`=0. Reset mid-BUSY drops `cyc`/`stb` on the next edge, with no ack handshake.
- With N wait states (ack arrives N cycles after `stb` rises), the fetch costs N+2 cycles from `cpu_ce_i`:
  - `stallreq_o` is high for N+1 cycles.
  - The instruction is presented in the ack cycle.
- Back-to-back: after a returning ack, the next IDLE cycle issues the next request immediately, so there is at least one idle bus cycle between Wishbone cycles.
- `stallreq_o`, `cpu_data_o` and `err_o` never produce X after reset.

## Test plan
- 0-wait read: after reset, `cpu_ce_i`=1, `cpu_addr_i`=0x0000_0004; the slave acks on the first `stb` cycle with 0x3401_1100. Required response:
  - `wb_adr_o`=0x0000_0004 and `sel`=4'hF.
  - `stallreq_o` is high for 1 cycle.
  - `cpu_data_o`=0x3401_1100 in the ack cycle, then 0 in IDLE.
- 3-wait read: the slave acks 3 cycles after `stb` with 0x0000_1020. Required: `stallreq_o` high exactly 4 cycles, `cyc`/`stb` high 4 cycles, data is correct in the ack cycle.
- Ack during external stall: `stall_i`=6'b001111 held for 3 cycles from the ack. Required:
  - WAIT_STALL is entered.
  - `cpu_data_o` holds the word and `stallreq_o`=0 throughout.
  - Return to IDLE the cycle after `stall_i`=0.
- Flush mid-BUSY: `flush_i` pulses 1 cycle into a 5-wait fetch. Required:
  - `cyc`/`stb` are low on the next edge.
  - The late ack is ignored and `cpu_data_o` stays 0.
- Timeout: `TIMEOUT`=8, the slave never acks. Required: `cyc` drops after 8 BUSY cycles, `err_o` is a single-cycle pulse, `stallreq_o`=0 from that cycle.
- Reset mid-BUSY: `rst`=1 for one cycle during a wait state. Required: all outputs are 0 on the next edge; a fresh fetch then completes normally.
